// File: rtl/fpu_pkg.sv
// Shared types and the round-robin pick function for the FPU adder arbiter.
`default_nettype none

package fpu_pkg;

  localparam int MAXN = 8;
  localparam int TAGW = 3;

  typedef enum logic [1:0] {
    OK  = 2'b00,
    NAN = 2'b01,
    INF = 2'b10,
    NUL = 2'b11
  } add_state_e;

  typedef struct packed {
    logic            vld;
    logic [TAGW-1:0] id;
  } fpu_tag_t;

  // Search ptr+1, ptr+2, ... (mod n); the pointer itself is the last candidate.
  function automatic logic [MAXN-1:0] rr_pick(input logic [MAXN-1:0] req,
                                              input logic [TAGW-1:0] ptr,
                                              input int unsigned     n);
    logic [MAXN-1:0] gnt;
    logic [TAGW-1:0] idx;
    gnt = '0;
    idx = '0;
    for (int unsigned k = 1; k <= MAXN; k++) begin
      if (k <= n && gnt == '0) begin
        idx = TAGW'((32'(ptr) + k) % n);
        if (req[idx]) gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick over N requesters with an externally held pointer.
`default_nettype none

module rr_arbiter
  import fpu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req_i,
  input  logic [TAGW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o
);

  logic [MAXN-1:0] req_ext;
  logic [MAXN-1:0] gnt_ext;
  logic            unused_gnt;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req_i;
    gnt_ext        = rr_pick(req_ext, ptr_i, N);
  end

  assign gnt_o      = gnt_ext[N-1:0];
  assign unused_gnt = ^gnt_ext;

endmodule

`default_nettype wire

// File: rtl/shift_reg_base.sv
// Resettable fixed-length shift register; every stage is exposed on taps_o.
`default_nettype none

module shift_reg_base #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        d_i,
  output logic [WIDTH-1:0]        q_o,
  output logic [STAGES*WIDTH-1:0] taps_o
);

  logic [STAGES*WIDTH-1:0] stage_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q[WIDTH-1:0] <= d_i;
      for (int s = 1; s < STAGES; s++) begin
        stage_q[s*WIDTH +: WIDTH] <= stage_q[(s-1)*WIDTH +: WIDTH];
      end
    end
  end

  assign q_o    = stage_q[(STAGES-1)*WIDTH +: WIDTH];
  assign taps_o = stage_q;

endmodule

`default_nettype wire

// File: rtl/fpu_add_arbiter.sv
// Round-robin sharing of one pipelined FP adder among N requesters, with
// tagged issue, result routing and a per-requester in-flight limit.
`default_nettype none

module fpu_add_arbiter
  import fpu_pkg::*;
#(
  parameter int N       = 4,
  parameter int LAT     = 6,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req_vld,
  output logic [N-1:0]    req_rdy,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  output logic [31:0]     add_a,
  output logic [31:0]     add_b,
  output logic            add_arg_vld,
  input  logic [31:0]     add_result,
  input  logic [1:0]      add_state,
  input  logic            add_res_vld,
  output logic [N-1:0]    rsp_vld,
  output logic [31:0]     rsp_result,
  output logic [1:0]      rsp_state,
  output logic            busy,
  output logic            err
);

  localparam int CNTW = $clog2(MAX_OUT + 1);
  localparam int TW   = 1 + TAGW;

  logic [CNTW-1:0] cnt_q [N];
  logic [TAGW-1:0] rr_q;
  logic [31:0]     add_a_q, add_b_q;
  logic            add_arg_vld_q;
  logic [TAGW-1:0] tag_q;
  logic [N-1:0]    rsp_vld_q;
  logic [31:0]     rsp_result_q;
  logic [1:0]      rsp_state_q;
  logic            err_q;

  logic [N-1:0]      elig;
  logic [N-1:0]      gnt;
  logic [N-1:0]      xfer;
  logic [TAGW-1:0]   win_id;
  logic [31:0]       win_a, win_b;
  logic [TW-1:0]     line_out;
  logic [LAT*TW-1:0] line_taps;
  fpu_tag_t          line;
  logic [N-1:0]      rsp_d;
  logic              mismatch;
  logic              busy_d;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = req_vld[i] & en & (cnt_q[i] < CNTW'(MAX_OUT));
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .req_i (elig),
    .ptr_i (rr_q),
    .gnt_o (gnt)
  );

  assign req_rdy = gnt;
  assign xfer    = req_vld & gnt;

  always_comb begin
    win_id = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        win_id = TAGW'(i);
        win_a  = req_a[32*i +: 32];
        win_b  = req_b[32*i +: 32];
      end
    end
  end

  // Tag enters the line together with add_arg_vld so its output lines up with add_res_vld.
  shift_reg_base #(.WIDTH(TW), .STAGES(LAT)) u_tag_line (
    .clk    (clk),
    .rst    (rst),
    .d_i    ({add_arg_vld_q, tag_q}),
    .q_o    (line_out),
    .taps_o (line_taps)
  );

  assign line     = line_out;
  assign mismatch = line.vld ^ add_res_vld;

  always_comb begin
    rsp_d = '0;
    for (int i = 0; i < N; i++) begin
      if (line.vld && add_res_vld && line.id == TAGW'(i)) rsp_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q          <= '0;
      add_a_q       <= '0;
      add_b_q       <= '0;
      add_arg_vld_q <= 1'b0;
      tag_q         <= '0;
      rsp_vld_q     <= '0;
      rsp_result_q  <= '0;
      rsp_state_q   <= '0;
      err_q         <= 1'b0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      add_arg_vld_q <= |xfer;
      if (|xfer) begin
        add_a_q <= win_a;
        add_b_q <= win_b;
        tag_q   <= win_id;
        rr_q    <= win_id;
      end
      rsp_vld_q <= rsp_d;
      if (|rsp_d) begin
        rsp_result_q <= add_result;
        rsp_state_q  <= add_state;
      end
      err_q <= err_q | mismatch;
      // Released slot is visible to the arbiter in the same cycle the response pulses.
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_q[i] + CNTW'(xfer[i]) - CNTW'(rsp_d[i]);
      end
    end
  end

  always_comb begin
    busy_d = add_arg_vld_q | (|rsp_vld_q);
    for (int i = 0; i < N; i++) begin
      if (cnt_q[i] != '0) busy_d = 1'b1;
    end
    for (int s = 0; s < LAT; s++) begin
      if (line_taps[s*TW + TAGW]) busy_d = 1'b1;
    end
  end

  assign add_a       = add_a_q;
  assign add_b       = add_b_q;
  assign add_arg_vld = add_arg_vld_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_state   = rsp_state_q;
  assign busy        = busy_d;
  assign err         = err_q;

  for (genvar i = 0; i < N; i++) begin : g_cnt_chk
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(xfer[i] && !rsp_d[i] && cnt_q[i] == CNTW'(MAX_OUT)));
    a_no_underflow : assert property (@(posedge clk) disable iff (!rst)
      !(rsp_d[i] && !xfer[i] && cnt_q[i] == '0));
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter with a behavioural fixed-latency adder.
`default_nettype none

module tb_fpu_add_arbiter;

  localparam int N       = 4;
  localparam int LAT     = 6;
  localparam int MAX_OUT = 2;
  localparam int NV      = 5;

  logic            clk;
  logic            rst;
  logic            en;
  logic [N-1:0]    req_vld;
  logic [N-1:0]    req_rdy;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [31:0]     add_a, add_b;
  logic            add_arg_vld;
  logic [31:0]     add_result;
  logic [1:0]      add_state;
  logic            add_res_vld;
  logic [N-1:0]    rsp_vld;
  logic [31:0]     rsp_result;
  logic [1:0]      rsp_state;
  logic            busy;
  logic            err;

  fpu_add_arbiter #(.N(N), .LAT(LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .add_a(add_a), .add_b(add_b), .add_arg_vld(add_arg_vld),
    .add_result(add_result), .add_state(add_state), .add_res_vld(add_res_vld),
    .rsp_vld(rsp_vld), .rsp_result(rsp_result), .rsp_state(rsp_state),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder model: integer sum (plus one genuine float case), status from b[1:0].
  logic [31:0] m_a [LAT];
  logic [31:0] m_b [LAT];
  logic        m_v [LAT];
  int          m_issued;
  int          drop_at;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        m_v[i] <= 1'b0; m_a[i] <= '0; m_b[i] <= '0;
      end
    end else begin
      m_v[0] <= add_arg_vld && (m_issued != drop_at);
      m_a[0] <= add_a;
      m_b[0] <= add_b;
      for (int i = 1; i < LAT; i++) begin
        m_v[i] <= m_v[i-1]; m_a[i] <= m_a[i-1]; m_b[i] <= m_b[i-1];
      end
      if (add_arg_vld) m_issued <= m_issued + 1;
    end
  end

  assign add_res_vld = m_v[LAT-1];
  assign add_result  = (m_a[LAT-1] == 32'h3F80_0000 && m_b[LAT-1] == 32'h4000_0000) ?
                       32'h4040_0000 : m_a[LAT-1] + m_b[LAT-1];
  assign add_state   = m_b[LAT-1][1:0];

  int n_vec;
  int n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [1:0]  st;
  } vec_t;

  vec_t tbl [NV];

  initial begin
    tbl[0] = '{idx: 2, a: 32'h3F80_0000, b: 32'h4000_0000, res: 32'h4040_0000, st: 2'b00};
    tbl[1] = '{idx: 0, a: 32'h0000_0010, b: 32'h0000_0021, res: 32'h0000_0031, st: 2'b01};
    tbl[2] = '{idx: 1, a: 32'h1234_0000, b: 32'h0000_5672, res: 32'h1234_5672, st: 2'b10};
    tbl[3] = '{idx: 3, a: 32'hFFFF_FFFF, b: 32'h0000_0003, res: 32'h0000_0002, st: 2'b11};
    tbl[4] = '{idx: 3, a: 32'h7F80_0000, b: 32'h0080_0001, res: 32'h8000_0001, st: 2'b01};

    n_vec = 0; n_bad = 0; m_issued = 0; drop_at = -1;
    rst = 1'b0; en = 1'b1; req_vld = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(req_rdy), 32'h0);
    chk("rst_arg_vld", 32'(add_arg_vld), 32'h0);
    chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
    chk("rst_busy_err", {30'h0, busy, err}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single operations from the vector table.
    for (int v = 0; v < NV; v++) begin
      int seen;
      logic [N-1:0] cv;
      logic [31:0]  cr;
      logic [1:0]   cs;
      seen = 0; cv = '0; cr = '0; cs = '0;
      req_vld = '0;
      req_vld[tbl[v].idx] = 1'b1;
      req_a[32*tbl[v].idx +: 32] = tbl[v].a;
      req_b[32*tbl[v].idx +: 32] = tbl[v].b;
      #1 chk($sformatf("vec%0d_rdy", v), 32'(req_rdy), 32'h1 << tbl[v].idx);
      @(negedge clk);
      req_vld = '0;
      for (int k = 1; k <= 12; k++) begin
        if (seen == 0 && rsp_vld != '0) begin
          seen = k; cv = rsp_vld; cr = rsp_result; cs = rsp_state;
        end
        @(negedge clk);
      end
      chk($sformatf("vec%0d_latency", v), 32'(seen), 32'd8);
      chk($sformatf("vec%0d_rsp_vld", v), 32'(cv), 32'h1 << tbl[v].idx);
      chk($sformatf("vec%0d_result", v), cr, tbl[v].res);
      chk($sformatf("vec%0d_state", v), 32'(cs), 32'(tbl[v].st));
    end

    // Fairness: all requesters held high; pointer sits at 3 after the table.
    for (int c = 0; c <= 20; c++) begin
      req_vld = (c < 12) ? '1 : '0;
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = 32'(c);
        req_b[32*i +: 32] = 32'h100;
      end
      #1;
      if (c < 12) chk($sformatf("fair_gnt%0d", c), 32'(req_rdy), 32'h1 << (c % 4));
      if (c >= 8 && c < 20) begin
        chk($sformatf("fair_rsp%0d", c), 32'(rsp_vld), 32'h1 << ((c - 8) % 4));
        chk($sformatf("fair_res%0d", c), rsp_result, 32'(c - 8) + 32'h100);
      end
      if (c == 19) chk("fair_busy_last", 32'(busy), 32'h1);
      if (c == 20) chk("fair_busy_idle", 32'(busy), 32'h0);
      @(negedge clk);
    end

    // In-flight limit on requester 0.
    for (int c = 0; c <= 8; c++) begin
      req_vld = 4'b0001;
      req_a[31:0] = 32'h55;
      req_b[31:0] = 32'h0;
      #1 chk($sformatf("lim_rdy%0d", c), 32'(req_rdy), (c < 2 || c == 8) ? 32'h1 : 32'h0);
      if (c == 8) chk("lim_rsp", 32'(rsp_vld), 32'h1);
      if (c == 8) req_vld = '0;
      @(negedge clk);
    end
    for (int k = 0; k < 30 && busy; k++) @(negedge clk);
    chk("lim_drained", 32'(busy), 32'h0);

    // Drain with en dropped after three issues.
    for (int c = 0; c <= 11; c++) begin
      req_vld = 4'b1110;
      en = (c < 3);
      for (int i = 0; i < N; i++) req_a[32*i +: 32] = 32'h10 * 32'(i);
      #1;
      if (c < 3) chk($sformatf("drn_gnt%0d", c), 32'(req_rdy), 32'h2 << c);
      else       chk($sformatf("drn_rdy%0d", c), 32'(req_rdy), 32'h0);
      if (c >= 8 && c <= 10) chk($sformatf("drn_rsp%0d", c), 32'(rsp_vld), 32'h1 << (c - 7));
      if (c == 10) chk("drn_busy_last", 32'(busy), 32'h1);
      if (c == 11) chk("drn_busy_idle", 32'(busy), 32'h0);
      @(negedge clk);
    end
    req_vld = '0;
    en = 1'b1;
    @(negedge clk);

    // Suppressed adder result.
    begin
      logic any_rsp;
      any_rsp = 1'b0;
      drop_at = m_issued;
      req_vld = 4'b0100;
      #1 chk("mis_rdy", 32'(req_rdy), 32'h4);
      @(negedge clk);
      req_vld = '0;
      for (int c = 1; c <= 12; c++) begin
        if (rsp_vld != '0) any_rsp = 1'b1;
        if (c == 7)  chk("mis_err_before", 32'(err), 32'h0);
        if (c == 8)  chk("mis_err_set", 32'(err), 32'h1);
        if (c == 12) chk("mis_err_sticky", 32'(err), 32'h1);
        @(negedge clk);
      end
      chk("mis_no_rsp", 32'(any_rsp), 32'h0);
      drop_at = -1;
    end

    // Reset in the middle of two in-flight operations.
    for (int c = 0; c <= 3; c++) begin
      req_vld = (c < 2) ? 4'b0011 : 4'b0000;
      req_a[31:0] = 32'hA5A5_0000; req_a[63:32] = 32'h5A5A_0000;
      #1 if (c < 2) chk($sformatf("rmf_gnt%0d", c), 32'(req_rdy), 32'h1 << c);
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    chk("rmf_add_a", add_a, 32'h0);
    chk("rmf_rsp_res", rsp_result, 32'h0);
    chk("rmf_busy_err", {30'h0, busy, err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    req_vld = '1;
    #1 chk("rmf_first_gnt", 32'(req_rdy), 32'h2);
    @(negedge clk);
    req_vld = '0;
    begin
      int seen;
      seen = 0;
      for (int k = 1; k <= 12; k++) begin
        if (seen == 0 && rsp_vld != '0) begin
          seen = k;
          chk("rmf_rsp_vld", 32'(rsp_vld), 32'h2);
        end
        @(negedge clk);
      end
      chk("rmf_latency", 32'(seen), 32'd8);
      chk("rmf_err", 32'(err), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
